host_input_loader: RTL and testbench
====================================

// Module: host_input_loader
// PURPOSE
//  Host-to-switch loader: the write-side counterpart of the host read-out buffer.
//  Avalon-MM slave writes 32-bit words into one of three input RAM FIFOs (one per switch port).
//  Switch-side consumers pop words through a 1-cycle-latency read interface.
//  Exposes per-port RAM read/write addresses so the read-out side can report them as debug registers.
// PARAMETERS
//  ADDR_W   12   RAM address width; FIFO depth per port = 2**ADDR_W words
//  DATA_W   32   word width (bus and RAM)
// PORTS
//  clk           in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  chipselect    in   1        Avalon slave select
//  write         in   1        Avalon write strobe (valid with chipselect)
//  read          in   1        Avalon read strobe (valid with chipselect)
//  address       in   4        register index
//  writedata     in   DATA_W   host write data
//  readdata      out  DATA_W   host read data, registered, 1-cycle latency
//  rd_req        in   3        per-port pop request, bit n = port n+1
//  rd_valid      out  3        bit n high the cycle rd_data(n+1) holds a popped word
//  rd_data1..3   out  DATA_W   popped word, ports 1..3
//  empty         out  3        per-port FIFO empty (combinational from count)
//  wr_add1..3    out  ADDR_W   current RAM write pointer, ports 1..3
//  rd_add1..3    out  ADDR_W   current RAM read pointer, ports 1..3
// BEHAVIOUR
//  Reset: all pointers, counts, SEL, OVF, readdata, rd_valid and rd_data* go to 0; empty = 3'b111.
//  Write map (chipselect && write):
//   0 DATA : push writedata into port SEL+1. Push to a full port is dropped; OVF[SEL] set (sticky).
//   1 SEL  : SEL <= writedata[1:0]. Value 3 is ignored; SEL holds.
//   2 CLEAR: for each set bit n of writedata[2:0], zero wr/rd pointer, count and OVF of port n+1.
//   Other addresses: no effect.
//  Read map (chipselect && read), readdata valid on the next cycle:
//   0 STATUS: [2:0] empty, [5:3] full, [8:6] OVF, [10:9] SEL, rest 0.
//   1..3 COUNT: count of port 1..3, zero-extended (ADDR_W+1 bits).
//   Others: 32'hFF. readdata holds its last value when not read.
//  Per-port FIFO:
//   - count is ADDR_W+1 bits; full = (count == 2**ADDR_W); empty = (count == 0).
//   - push writes RAM[wr_add]; wr_add increments mod 2**ADDR_W, wrapping to 0.
//   - pop on rd_req[n] && !empty[n]: rd_add increments with wrap; rd_data valid next cycle, rd_valid[n]=1.
//   - rd_req on an empty port is ignored: rd_valid=0, rd_data holds.
//  Concurrency:
//   - push+pop on the same port in one cycle: both happen and count is unchanged. A pop at count 0
//     is ignored even when a push arrives that cycle.
//   - push to a full port with a simultaneous pop: push accepted, no OVF.
//   - CLEAR with a same-cycle pop on that port: CLEAR wins, rd_valid=0 next cycle.
//  RAMs: simple dual-port, registered read, one cycle read latency; no read-during-write bypass is
//  needed, because a pop only reads words already committed.
//  Reset mid-transfer discards all FIFO contents. RAM data is not cleared.
// TESTING
//  1 Reset, then read STATUS -> readdata=32'h7 (all empty, SEL 0), COUNT1..3 = 0, addr 5 read -> 32'hFF.
//  2 SEL=1; DATA writes 0xA,0xB,0xC; COUNT2=3; rd_req[1] x3 -> rd_data2 = A,B,C each 1 cycle later,
//    with rd_valid[1] pulses; a 4th pop gives rd_valid[1]=0; empty[1]=1.
//  3 ADDR_W=2: SEL=0, push 5 words 1..5 -> COUNT1=4, full[0]=1, OVF[0]=1 (STATUS bit6); pops return 1..4.
//  4 ADDR_W=2 wrap: push 3, pop 3, push 3 -> wr_add1 = 2, rd_add1 = 3, pops return the second batch in order.
//  5 Port 3 at count 4 (full, ADDR_W=2): push+pop same cycle -> count stays 4, no OVF. At count 0:
//    push+pop -> count 1, rd_valid[2]=0.
//  6 Port 1 at count 2 with OVF set: CLEAR 3'b001 with same-cycle rd_req[0] -> count 0, OVF[0]=0,
//    pointers 0, rd_valid[0]=0. Ports 2/3 are unchanged.

Source files
------------

// File: rtl/host_input_loader_if.sv
// Avalon-MM slave bus used by the host to load words into the switch input FIFOs.
interface host_input_loader_if #(
   parameter int DATA_W = 32
);
   logic              chipselect;
   logic              write;
   logic              read;
   logic [3:0]        address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (
      output chipselect, write, read, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write, read, address, writedata,
      output readdata
   );
endinterface

// File: rtl/host_input_loader.sv
// Host-to-switch loader: three RAM FIFOs filled over Avalon-MM, drained by switch-side pops
// with one cycle of read latency.
module host_input_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   host_input_loader_if.slave  bus,
   input  logic [2:0]          rd_req,
   output logic [2:0]          rd_valid,
   output logic [DATA_W-1:0]   rd_data1,
   output logic [DATA_W-1:0]   rd_data2,
   output logic [DATA_W-1:0]   rd_data3,
   output logic [2:0]          empty,
   output logic [ADDR_W-1:0]   wr_add1,
   output logic [ADDR_W-1:0]   wr_add2,
   output logic [ADDR_W-1:0]   wr_add3,
   output logic [ADDR_W-1:0]   rd_add1,
   output logic [ADDR_W-1:0]   rd_add2,
   output logic [ADDR_W-1:0]   rd_add3
);
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic              wr_en;
   logic              rd_en;
   logic              data_wr;
   logic              sel_wr;
   logic [2:0]        clear_mask;
   logic [1:0]        sel_reg;
   logic [2:0]        full;
   logic [2:0]        ovf;
   logic [DATA_W-1:0] readdata_reg;

   logic [ADDR_W-1:0] wr_ptr  [3];
   logic [ADDR_W-1:0] rd_ptr  [3];
   logic [ADDR_W:0]   count   [3];
   logic [DATA_W-1:0] rd_word [3];

   assign wr_en      = bus.chipselect & bus.write;
   assign rd_en      = bus.chipselect & bus.read;
   assign data_wr    = wr_en && (bus.address == 4'd0);
   assign sel_wr     = wr_en && (bus.address == 4'd1);
   assign clear_mask = (wr_en && (bus.address == 4'd2)) ? bus.writedata[2:0] : 3'b000;

   // Port select; the value 3 does not name a port and leaves SEL unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_reg <= 2'd0;
      end else if (sel_wr && (bus.writedata[1:0] != 2'd3)) begin
         sel_reg <= bus.writedata[1:0];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_port
         logic [DATA_W-1:0] ram [2**ADDR_W];
         logic [ADDR_W-1:0] wr_ptr_reg;
         logic [ADDR_W-1:0] rd_ptr_reg;
         logic [ADDR_W:0]   count_reg;
         logic [DATA_W-1:0] rd_word_reg;
         logic              ovf_reg;
         logic              valid_reg;
         logic              push;
         logic              pop;
         logic              push_ok;
         logic              clr;
         logic              is_empty;
         logic              is_full;

         assign is_empty = (count_reg == '0);
         assign is_full  = (count_reg == FULL_CNT);
         assign clr      = clear_mask[gi];
         assign push     = data_wr && (sel_reg == 2'(gi));
         assign pop      = rd_req[gi] && !is_empty && !clr;
         // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
         assign push_ok  = push && (!is_full || pop);

         always_ff @(posedge clk) begin
            if (push_ok) begin
               ram[wr_ptr_reg] <= bus.writedata;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr_reg  <= '0;
               rd_ptr_reg  <= '0;
               count_reg   <= '0;
               rd_word_reg <= '0;
               ovf_reg     <= 1'b0;
               valid_reg   <= 1'b0;
            end else if (clr) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               ovf_reg    <= 1'b0;
               valid_reg  <= 1'b0;
            end else begin
               valid_reg <= pop;
               if (push_ok) begin
                  wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
               end
               if (pop) begin
                  rd_ptr_reg  <= rd_ptr_reg + ADDR_W'(1);
                  rd_word_reg <= ram[rd_ptr_reg];
               end
               if (push && !push_ok) begin
                  ovf_reg <= 1'b1;
               end
               if (push_ok && !pop) begin
                  count_reg <= count_reg + (ADDR_W + 1)'(1);
               end else if (pop && !push_ok) begin
                  count_reg <= count_reg - (ADDR_W + 1)'(1);
               end
            end
         end

         assign wr_ptr[gi]   = wr_ptr_reg;
         assign rd_ptr[gi]   = rd_ptr_reg;
         assign count[gi]    = count_reg;
         assign rd_word[gi]  = rd_word_reg;
         assign empty[gi]    = is_empty;
         assign full[gi]     = is_full;
         assign ovf[gi]      = ovf_reg;
         assign rd_valid[gi] = valid_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_reg <= '0;
      end else if (rd_en) begin
         case (bus.address)
            4'd0:    readdata_reg <= DATA_W'({sel_reg, ovf, full, empty});
            4'd1:    readdata_reg <= DATA_W'(count[0]);
            4'd2:    readdata_reg <= DATA_W'(count[1]);
            4'd3:    readdata_reg <= DATA_W'(count[2]);
            default: readdata_reg <= DATA_W'(8'hFF);
         endcase
      end
   end

   assign bus.readdata = readdata_reg;

   assign rd_data1 = rd_word[0];
   assign rd_data2 = rd_word[1];
   assign rd_data3 = rd_word[2];
   assign wr_add1  = wr_ptr[0];
   assign wr_add2  = wr_ptr[1];
   assign wr_add3  = wr_ptr[2];
   assign rd_add1  = rd_ptr[0];
   assign rd_add2  = rd_ptr[1];
   assign rd_add3  = rd_ptr[2];
endmodule

// File: tb/tb_host_input_loader.sv
// Directed bench for host_input_loader (ADDR_W=2) with a FIFO model and an expected-pop queue.
module tb_host_input_loader;
   localparam int AW    = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   logic          clk;
   logic          reset;
   logic [2:0]    rd_req;
   logic [2:0]    rd_valid;
   logic [2:0]    empty;
   logic [DW-1:0] rd_data_o [3];
   logic [AW-1:0] wr_add_o  [3];
   logic [AW-1:0] rd_add_o  [3];

   host_input_loader_if #(.DATA_W(DW)) bus ();

   host_input_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .rd_req   (rd_req),
      .rd_valid (rd_valid),
      .rd_data1 (rd_data_o[0]),
      .rd_data2 (rd_data_o[1]),
      .rd_data3 (rd_data_o[2]),
      .empty    (empty),
      .wr_add1  (wr_add_o[0]),
      .wr_add2  (wr_add_o[1]),
      .wr_add3  (wr_add_o[2]),
      .rd_add1  (rd_add_o[0]),
      .rd_add2  (rd_add_o[1]),
      .rd_add3  (rd_add_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_fail;
   exp_t        exp_q [$];
   logic [31:0] m_mem [3][DEPTH];
   int          m_head [3];
   int          m_cnt  [3];
   logic [2:0]  m_ovf;
   logic [1:0]  m_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] status_exp();
      logic [2:0] e;
      logic [2:0] f;
      for (int p = 0; p < 3; p++) begin
         e[p] = (m_cnt[p] == 0);
         f[p] = (m_cnt[p] == DEPTH);
      end
      return {21'b0, m_sel, m_ovf, f, e};
   endfunction

   task automatic model_clear();
      for (int p = 0; p < 3; p++) begin
         m_head[p] = 0;
         m_cnt[p]  = 0;
      end
      m_ovf = 3'b000;
      m_sel = 2'd0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      rd_req         = 3'b000;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_clear();
   endtask

   // One bus cycle (optional write) plus pop requests; checks the pops that come back.
   task automatic step(input bit do_wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [2:0] req, input string tag);
      logic [2:0] clr;
      logic [2:0] pop;
      bit         push;
      bit         full_b;
      int         s;
      exp_t       e;
      clr    = (do_wr && a == 4'd2) ? d[2:0] : 3'b000;
      s      = int'(m_sel);
      push   = do_wr && (a == 4'd0);
      full_b = (m_cnt[s] == DEPTH);
      for (int p = 0; p < 3; p++) begin
         pop[p] = req[p] && (m_cnt[p] > 0) && !clr[p];
         if (pop[p]) begin
            exp_q.push_back('{p, m_mem[p][m_head[p]]});
            m_head[p] = (m_head[p] + 1) % DEPTH;
            m_cnt[p]--;
         end
      end
      if (push) begin
         if (full_b && !pop[s]) begin
            m_ovf[s] = 1'b1;
         end else begin
            m_mem[s][(m_head[s] + m_cnt[s]) % DEPTH] = d;
            m_cnt[s]++;
         end
      end
      if (do_wr && a == 4'd1 && d[1:0] != 2'd3) m_sel = d[1:0];
      for (int p = 0; p < 3; p++) begin
         if (clr[p]) begin
            m_head[p] = 0;
            m_cnt[p]  = 0;
            m_ovf[p]  = 1'b0;
         end
      end
      bus.chipselect = do_wr;
      bus.write      = do_wr;
      bus.address    = a;
      bus.writedata  = d;
      rd_req         = req;
      tick();
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      rd_req         = 3'b000;
      $display("step %s: wr=%0b addr=%0d data=%h req=%b -> rd_valid=%b", tag, do_wr, a, d, req, rd_valid);
      chk($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'(pop));
      for (int p = 0; p < 3; p++) begin
         if (pop[p]) begin
            e = exp_q.pop_front();
            chk($sformatf("%s.rd_data%0d", tag, e.port + 1), rd_data_o[e.port], e.data);
         end
      end
   endtask

   task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp, input string tag);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = a;
      tick();
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      $display("read %s: addr=%0d readdata=%h", tag, a, bus.readdata);
      chk(tag, bus.readdata, exp);
   endtask

   task automatic chk_ptrs(input string tag);
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("%s.wr_add%0d", tag, p + 1), 32'(wr_add_o[p]),
             32'((m_head[p] + m_cnt[p]) % DEPTH));
         chk($sformatf("%s.rd_add%0d", tag, p + 1), 32'(rd_add_o[p]), 32'(m_head[p]));
         chk($sformatf("%s.empty%0d", tag, p + 1), 32'(empty[p]), 32'(m_cnt[p] == 0));
      end
   endtask

   task automatic rd_counts(input string tag);
      for (int p = 0; p < 3; p++) begin
         rd_reg(4'(p + 1), 32'(m_cnt[p]), $sformatf("%s.count%0d", tag, p + 1));
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_fail         = 0;
      reset          = 1'b1;
      rd_req         = 3'b000;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      bus.address    = 4'd0;
      bus.writedata  = 32'd0;
      model_clear();

      // 1: reset state and register map
      do_reset();
      chk("rst.readdata", bus.readdata, 32'h0);
      chk("rst.rd_valid", 32'(rd_valid), 32'h0);
      chk("rst.rd_data1", rd_data_o[0], 32'h0);
      chk("rst.empty", 32'(empty), 32'h7);
      chk_ptrs("rst");
      rd_reg(4'd0, 32'h7, "rst.status");
      rd_counts("rst");
      rd_reg(4'd5, 32'hFF, "rst.addr5");
      rd_reg(4'd15, 32'hFF, "rst.addr15");

      // 2: port 2 push three, pop three, then pop on empty
      step(1, 4'd1, 32'd1, 3'b000, "sel1");
      step(1, 4'd0, 32'hA, 3'b000, "p2.pushA");
      step(1, 4'd0, 32'hB, 3'b000, "p2.pushB");
      step(1, 4'd0, 32'hC, 3'b000, "p2.pushC");
      rd_reg(4'd2, 32'd3, "p2.count");
      rd_reg(4'd0, status_exp(), "p2.status");
      for (int i = 0; i < 4; i++) step(0, 4'd0, 32'd0, 3'b010, $sformatf("p2.pop%0d", i));
      chk_ptrs("p2");
      // SEL=3 is ignored; unmapped write has no effect
      step(1, 4'd1, 32'd3, 3'b000, "sel3");
      step(1, 4'd9, 32'hFFFF_FFFF, 3'b000, "wr9");
      rd_reg(4'd0, status_exp(), "sel3.status");

      // 3: port 1 overflow
      step(1, 4'd1, 32'd0, 3'b000, "sel0");
      for (int i = 1; i <= 5; i++) step(1, 4'd0, 32'(i), 3'b000, $sformatf("p1.push%0d", i));
      rd_reg(4'd1, 32'd4, "p1.count_full");
      rd_reg(4'd0, status_exp(), "p1.status_ovf");
      for (int i = 0; i < 4; i++) step(0, 4'd0, 32'd0, 3'b001, $sformatf("p1.pop%0d", i));

      // 4: pointer wrap on port 1
      step(1, 4'd2, 32'h1, 3'b000, "p1.clr");
      for (int i = 0; i < 3; i++) step(1, 4'd0, 32'h10 + 32'(i), 3'b000, $sformatf("w.pushA%0d", i));
      for (int i = 0; i < 3; i++) step(0, 4'd0, 32'd0, 3'b001, $sformatf("w.popA%0d", i));
      for (int i = 0; i < 3; i++) step(1, 4'd0, 32'h20 + 32'(i), 3'b000, $sformatf("w.pushB%0d", i));
      chk("w.wr_add1", 32'(wr_add_o[0]), 32'd2);
      chk("w.rd_add1", 32'(rd_add_o[0]), 32'd3);
      for (int i = 0; i < 3; i++) step(0, 4'd0, 32'd0, 3'b001, $sformatf("w.popB%0d", i));
      chk_ptrs("wrap");

      // 5: port 3 push+pop when full and when empty
      step(1, 4'd1, 32'd2, 3'b000, "sel2");
      for (int i = 0; i < 4; i++) step(1, 4'd0, 32'h30 + 32'(i), 3'b000, $sformatf("p3.push%0d", i));
      step(1, 4'd0, 32'h34, 3'b100, "p3.full_pushpop");
      rd_reg(4'd3, 32'd4, "p3.count_full");
      rd_reg(4'd0, status_exp(), "p3.status_noovf");
      for (int i = 0; i < 4; i++) step(0, 4'd0, 32'd0, 3'b100, $sformatf("p3.pop%0d", i));
      step(1, 4'd0, 32'h35, 3'b100, "p3.empty_pushpop");
      rd_reg(4'd3, 32'd1, "p3.count_one");

      // 6: CLEAR on port 1 beats a same-cycle pop
      step(1, 4'd1, 32'd0, 3'b000, "sel0b");
      for (int i = 0; i < 5; i++) step(1, 4'd0, 32'h40 + 32'(i), 3'b000, $sformatf("c.push%0d", i));
      step(0, 4'd0, 32'd0, 3'b001, "c.pop0");
      step(0, 4'd0, 32'd0, 3'b001, "c.pop1");
      rd_reg(4'd0, status_exp(), "c.status_pre");
      step(1, 4'd2, 32'h1, 3'b001, "c.clear_pop");
      chk_ptrs("clr");
      rd_reg(4'd0, status_exp(), "c.status_post");
      rd_counts("clr");
      step(0, 4'd0, 32'd0, 3'b100, "c.p3pop");

      // Reset mid-transfer discards queued words
      step(1, 4'd1, 32'd1, 3'b000, "r.sel1");
      step(1, 4'd0, 32'h55, 3'b000, "r.push0");
      step(1, 4'd0, 32'h66, 3'b000, "r.push1");
      do_reset();
      rd_reg(4'd0, 32'h7, "r.status");
      step(0, 4'd0, 32'd0, 3'b111, "r.pop_empty");
      chk_ptrs("r");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
